// File: rtl/irom_loader.sv
// Boot-time loader: parses a framed byte stream (A5, count, words, checksum), writes
// 16-bit words into the instruction ROM from address 0, and enables the CPU on success.
module irom_loader #(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned AWIDTH = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              rom_we,
    output logic [AWIDTH-1:0] rom_addr,
    output logic [DWIDTH-1:0] rom_wdata,
    output logic              cpu_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        StIdle,
        StCntHi,
        StCntLo,
        StDataHi,
        StDataLo,
        StCheck,
        StDone,
        StErr
    } state_e;

    localparam logic [7:0] SyncByte = 8'hA5;

    state_e            state_q, state_d;
    logic [7:0]        cnt_hi_q, cnt_hi_d;
    logic [11:0]       count_q, count_d;
    logic [AWIDTH-1:0] word_q, word_d;
    logic [7:0]        data_hi_q, data_hi_d;
    logic [7:0]        sum_q, sum_d;
    logic              in_ready_q, in_ready_d;
    logic              rom_we_q, rom_we_d;
    logic [AWIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [DWIDTH-1:0] rom_wdata_q, rom_wdata_d;

    logic accept;
    logic last_word;

    assign accept    = in_valid && in_ready_q;
    assign last_word = (12'(word_q) == (count_q - 12'd1));

    always_comb begin
        state_d     = state_q;
        cnt_hi_d    = cnt_hi_q;
        count_d     = count_q;
        word_d      = word_q;
        data_hi_d   = data_hi_q;
        sum_d       = sum_q;
        rom_we_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        rom_wdata_d = rom_wdata_q;

        unique case (state_q)
            StIdle: begin
                // Non-sync bytes are consumed and dropped while hunting.
                if (accept && (in_data == SyncByte)) begin
                    state_d = StCntHi;
                    word_d  = '0;
                    sum_d   = '0;
                end
            end
            StCntHi: begin
                if (accept) begin
                    cnt_hi_d = in_data;
                    state_d  = StCntLo;
                end
            end
            StCntLo: begin
                if (accept) begin
                    count_d = {cnt_hi_q[3:0], in_data};
                    if (cnt_hi_q[7:4] != 4'h0) begin
                        state_d = StErr;
                    end else if ({cnt_hi_q, in_data} == 16'h0000) begin
                        state_d = StCheck;
                    end else begin
                        state_d = StDataHi;
                    end
                end
            end
            StDataHi: begin
                if (accept) begin
                    data_hi_d = in_data;
                    state_d   = StDataLo;
                end
            end
            StDataLo: begin
                if (accept) begin
                    rom_we_d    = 1'b1;
                    rom_addr_d  = word_q;
                    rom_wdata_d = DWIDTH'({data_hi_q, in_data});
                    sum_d       = sum_q + data_hi_q + in_data;
                    word_d      = word_q + 1'b1;
                    state_d     = last_word ? StCheck : StDataHi;
                end
            end
            StCheck: begin
                if (accept) begin
                    state_d = (in_data == sum_q) ? StDone : StErr;
                end
            end
            StDone, StErr: begin
                if (clr) begin
                    state_d    = StIdle;
                    word_d     = '0;
                    sum_d      = '0;
                    rom_addr_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Registered ready tracks the next state so it drops on the same edge err/done rise.
    assign in_ready_d = (state_d != StDone) && (state_d != StErr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_hi_q    <= '0;
            count_q     <= '0;
            word_q      <= '0;
            data_hi_q   <= '0;
            sum_q       <= '0;
            in_ready_q  <= 1'b0;
            rom_we_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_hi_q    <= cnt_hi_d;
            count_q     <= count_d;
            word_q      <= word_d;
            data_hi_q   <= data_hi_d;
            sum_q       <= sum_d;
            in_ready_q  <= in_ready_d;
            rom_we_q    <= rom_we_d;
            rom_addr_q  <= rom_addr_d;
            rom_wdata_q <= rom_wdata_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign rom_we    = rom_we_q;
    assign rom_addr  = rom_addr_q;
    assign rom_wdata = rom_wdata_q;
    assign done      = (state_q == StDone);
    assign cpu_en    = (state_q == StDone);
    assign err       = (state_q == StErr);
    assign busy      = (state_q != StIdle) && (state_q != StDone) && (state_q != StErr);

endmodule

// File: doc/irom_loader.md
# irom_loader

Boot-time instruction loader sitting directly upstream of the CPU's instruction ROM. It receives a framed byte stream over a valid/ready interface, assembles 16-bit instruction words and writes them sequentially into the instruction memory from address 0. While loading it holds the CPU disabled. It drives the CPU's enable input only after a complete, checksum-verified image is written.

## Interface
- `DWIDTH`, 16, instruction word width; fixed at 16, two bytes per word.
- `AWIDTH`, 12, instruction memory address width.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `clr` input 1: synchronous clear; returns the block from DONE/ERR to IDLE.
- `in_data` input 8: byte stream data.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: loader can accept a byte. A byte transfers on a rising edge where `in_valid && in_ready`.
- `rom_we` output 1: instruction memory write strobe, one cycle per word.
- `rom_addr` output AWIDTH: write address.
- `rom_wdata` output DWIDTH: write data.
- `cpu_en` output 1: CPU enable, connected to the CPU's `en_in`.
- `busy` output 1: a frame is in progress (any state except IDLE, DONE, ERR).
- `done` output 1: image loaded and verified (sticky).
- `err` output 1: frame rejected (sticky).

## Operation
- Frame format: sync byte 0xA5, then count high byte, then count low byte, then count words sent high byte first, then a checksum byte.
- Checksum is the 8-bit modulo-256 sum of all data bytes. Sync and count bytes are excluded.
- States and transitions (each transition consumes one accepted byte unless noted):
  - IDLE: byte 0xA5 goes to CNT_HI. Any other byte is accepted and discarded.
  - CNT_HI: latch the high byte, go to CNT_LO.
  - CNT_LO: form the 16-bit count.
    - If count[15:12] != 0, go to ERR.
    - If count == 0, go to CHECK.
    - Otherwise go to DATA_HI.
  - DATA_HI: latch the high byte, go to DATA_LO.
  - DATA_LO: issue a write of {hi, lo} and add both bytes to the checksum. Go to CHECK if this was the last word, otherwise go to DATA_HI.
  - CHECK: if the byte equals the accumulated sum, go to DONE, otherwise go to ERR.
  - DONE / ERR: `in_ready`=0. Stay here until `clr` or `rst`.
- `clr` in DONE or ERR: go to IDLE and zero the word counter, address and checksum. `clr` in any other state is ignored.
- Word counter and address: both start at 0 for every frame. The address increments after each write and never wraps, because count ≤ 4095.
- No readback or verify of memory contents. A rejected frame leaves any words already written in memory; `cpu_en` stays 0.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready`=0; it is a registered output, set on the first rising edge after `rst` deasserts.
  - `rom_we`=0, `rom_addr`=0, `rom_wdata`=0.
  - `cpu_en`=0, `busy`=0, `done`=0, `err`=0.
- `rom_we`, `rom_addr` and `rom_wdata` are registered. The write occurs in the cycle after the low byte is accepted. `rom_we` is high for exactly one cycle per word.
- A checksum byte accepted in that same write cycle is legal. The final write always completes before `done` rises.
- `done` and `cpu_en` rise in the cycle after the matching checksum byte is accepted.
- `err` rises in the cycle after the offending byte is accepted. `in_ready` falls on that same edge.
- `clr`: on the edge where `clr` is sampled high in DONE/ERR, `done`, `err` and `cpu_en` clear and `in_ready` sets.
- `in_valid` gaps of any length are tolerated. State holds and no byte is lost or duplicated.
- `rst` mid-frame: all state and outputs return immediately to reset values, and any partial word is discarded. The next frame loads from address 0.
- Minimum load time: 4 + 2·count accepted bytes, plus 1 cycle to `cpu_en`.

## Test plan
- Basic load: send A5 00 02 12 34 AB CD BE → writes addr 0 = 0x1234 and addr 1 = 0xABCD; `done`=1, `cpu_en`=1, `err`=0.
- Bad checksum: same frame with final byte BF → both writes still occur; `err`=1, `cpu_en`=0, `in_ready`=0.
- Sync hunt and empty image: send 00 FF A5 00 00 00 → the first two bytes are discarded; `done`=1 with zero `rom_we` pulses.
- Oversize count: send A5 10 00 → `err`=1 after the third byte; no `rom_we`.
- Backpressure and reset:
  - Repeat the basic load with `in_valid` deasserted for 3 cycles between every byte → identical writes and `done`.
  - Assert `rst` after the first word is written → all outputs reset. A subsequent full frame writes starting at addr 0.
- Clear and reload: from DONE, pulse `clr` → `cpu_en` drops and `in_ready`=1 on the next edge. Then send A5 00 01 00 07 07 → addr 0 = 0x0007, `done`=1.
